// File: rtl/aluv_pkg.sv
// rtl/aluv_pkg.sv - shared state encoding and default sizing for the vector ALU slice
package aluv_pkg;

    localparam int ALUV_N     = 4;
    localparam int ALUV_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } aluv_state_t;

endpackage

// File: rtl/lane_pick.sv
// rtl/lane_pick.sv - lowest-set-bit priority encoder over a lane mask
module lane_pick #(
    parameter int  N  = 4,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    output logic [LW-1:0] idx,
    output logic          any
);

    // Scan high to low so the last match written is the lowest index.
    always_comb begin
        idx = '0;
        any = |mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = LW'(i);
            end
        end
    end

endmodule

// File: rtl/aluv_result_collector.sv
// rtl/aluv_result_collector.sv - snapshots N ALU lane results and drains the masked lanes as a stream
module aluv_result_collector
    import aluv_pkg::*;
#(
    parameter int  N     = ALUV_N,
    parameter int  WIDTH = ALUV_WIDTH,
    localparam int LW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [WIDTH*2-1:0]   Z [N-1:0],
    input  logic [N-1:0]         lane_mask,
    input  logic                 capture,
    output logic [WIDTH*2-1:0]   out_data,
    output logic [LW-1:0]        out_lane,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 drop
);

    aluv_state_t          state_q, state_d;
    logic [N-1:0]         pend_q, pend_d;
    logic [WIDTH*2-1:0]   shadow_q [N-1:0];
    logic                 drop_q, drop_d;
    logic                 load;
    logic                 accept;
    logic                 hs;
    logic [LW-1:0]        pick_idx;
    logic                 pick_any;

    lane_pick #(.N(N)) u_lane_pick (
        .mask (pend_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_lane  = pick_idx;
    assign out_data  = out_valid ? shadow_q[pick_idx] : '0;
    // Exactly one pending bit: nonzero and clearing the lowest bit leaves nothing.
    assign out_last  = pick_any && ((pend_q & (pend_q - N'(1))) == '0);
    assign drop      = drop_q;
    assign hs        = out_valid && out_ready;

    // A new frame is taken when idle, or on the final handshake of the current one.
    assign accept = capture && (|lane_mask) &&
                    ((state_q == IDLE) || (hs && out_last));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        load    = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    pend_d  = lane_mask;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    pend_d = pend_q & ~(N'(1) << pick_idx);
                end
                if (capture && !accept) begin
                    drop_d = 1'b1;
                end
                if (accept) begin
                    load   = 1'b1;
                    pend_d = lane_mask;
                end else if (hs && out_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            drop_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    shadow_q[i] <= Z[i];
                end
            end
        end
    end

endmodule

// File: doc/aluv_result_collector.md
ALUV_RESULT_COLLECTOR -- requirements
Module: aluv_result_collector

Interface
REQ-001 Parameter N, default 4, number of ALU lanes captured per frame.
REQ-002 Parameter WIDTH, default 8, operand width; each result is WIDTH*2 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 arst  input  1  reset, asynchronous and active-high.
REQ-005 Z  input  [WIDTH*2-1:0] x N (unpacked [N-1:0])  registered lane results from the vector ALU stage.
REQ-006 lane_mask  input  N  lanes to emit; normally the enable vector from the cycle that produced Z.
REQ-007 capture  input  1  one-cycle request to snapshot Z and lane_mask.
REQ-008 out_data  output  WIDTH*2  result of the lane currently offered.
REQ-009 out_lane  output  $clog2(N)  index of that lane.
REQ-010 out_valid  output  1  out_data/out_lane/out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
REQ-012 out_last  output  1  offered beat is the final pending lane of the frame.
REQ-013 busy  output  1  high in DRAIN.
REQ-014 drop  output  1  one-cycle pulse when a capture is rejected.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and DRAIN.
REQ-016 In IDLE, capture=1 with lane_mask!=0 SHALL latch all N Z values and lane_mask into shadow registers and move to DRAIN.
REQ-017 In IDLE, capture=1 with lane_mask==0 SHALL be ignored: state stays IDLE, drop stays 0.
REQ-018 out_valid SHALL be 1 exactly while in DRAIN; first beat is offered the cycle after the capture edge (latency 1).
REQ-019 The offered lane SHALL be the lowest-indexed set bit of the pending mask; out_data is the shadow value of that lane.
REQ-020 On a handshake the offered lane's pending bit SHALL clear; the next lane is offered the following cycle with no bubble.
REQ-021 out_last SHALL be 1 when exactly one pending bit remains.
REQ-022 While out_valid && !out_ready, out_data, out_lane, out_last SHALL hold stable.
REQ-023 A handshake on out_last SHALL return to IDLE, unless capture is also accepted per REQ-024.
REQ-024 If capture=1 with nonzero lane_mask coincides with the out_last handshake, the new frame SHALL be latched and the FSM stays in DRAIN (back-to-back frames, zero idle cycles).
REQ-025 capture=1 in DRAIN other than under REQ-024 SHALL be rejected: shadow state unchanged, drop=1 for that following cycle only.
REQ-026 Shadow data SHALL be captured untruncated at WIDTH*2 bits; no arithmetic is performed on it.
REQ-027 Z SHALL be sampled only on the accepting edge; later Z changes SHALL not affect the frame.

Reset
REQ-028 arst=1 SHALL immediately force IDLE, pending mask 0, out_valid 0, out_last 0, busy 0, drop 0, out_data 0, out_lane 0.
REQ-029 arst asserted mid-frame SHALL discard remaining lanes; after release no beat is emitted until a new capture.
REQ-030 Shadow data registers SHALL also reset to 0.

Structure
REQ-031 A shared package aluv_pkg SHALL hold the state enum (IDLE, DRAIN) and default N/WIDTH constants used by aluv_result_collector and the ALU vector stage.
REQ-032 One sub-module lane_pick SHALL implement the lowest-set-bit priority encoder (mask in; index and any-set out), combinational, parameterised by N.
REQ-033 All outputs SHALL be driven from registers or from the registered pending mask and shadow data via lane_pick only.

Verification
REQ-034 Z={0x0003,0x00F0,0x0010,0x0102}, lane_mask=4'b1011, capture, out_ready=1 -> beats (lane0,0x0102),(lane1,0x0010),(lane3,0x0003 ... per index mapping), out_last on lane3 only, busy low after beat 3.
REQ-035 lane_mask=4'b0100, out_ready=0 for 5 cycles then 1 -> out_valid high 5 cycles with lane 2 data stable, single beat with out_last=1.
REQ-036 Second capture (mask 4'b1111) two cycles into a 3-lane frame -> drop pulses 1 cycle, original frame completes unchanged, no lanes from second capture.
REQ-037 Capture (mask 4'b0011) coincident with out_last handshake of prior frame -> next cycle offers lane 0 of new frame, drop=0, busy never drops.
REQ-038 arst pulsed after 1 of 4 beats -> outputs zero immediately; after release out_valid stays 0 until new capture.
REQ-039 capture with lane_mask=0 in IDLE -> no beat, busy=0, drop=0.
